aes_rk_fetch: RTL

AES_RK_FETCH -- requirements
Module: aes_rk_fetch

---
 rtl/aes_rk_fetch.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/aes_rk_fetch.sv
`default_nettype none
// ============================================================================
// Module      : aes_rk_fetch
// Description : Fetches one 128-bit AES round key from a key expander, one
//               32-bit word per cycle, and hands it to a consumer.
// Revision    : 1.0
// ============================================================================
module aes_rk_fetch #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ke_done,
  input  logic [31:0]  ke_round_key,
  output logic [3:0]   ke_round_key_num,
  output logic [1:0]   ke_r_index,
  input  logic         req_valid,
  input  logic [3:0]   req_num,
  output logic         req_ready,
  output logic         rk_valid,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_num,
  input  logic         rk_ready,
  output logic         err_range,
  output logic         abort
);

  localparam logic [3:0] c_max_num = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     num_q, num_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [127:0]   asm_q, asm_d;
  logic [127:0]   rk_data_q, rk_data_d;
  logic [3:0]     rk_num_q, rk_num_d;
  logic           rk_valid_q, rk_valid_d;
  logic           err_q, err_d;
  logic           abort_q, abort_d;

  logic           w_accept;
  logic [127:0]   w_asm_new;

  assign req_ready        = ke_done && ((state_q == IDLE) || ((state_q == HOLD) && rk_ready));
  assign w_accept         = req_valid && req_ready;
  assign ke_round_key_num = num_q;
  assign ke_r_index       = (state_q == FETCH) ? cnt_q : 2'd0;
  assign rk_valid         = rk_valid_q;
  assign rk_data          = rk_data_q;
  assign rk_num           = rk_num_q;
  assign err_range        = err_q;
  assign abort            = abort_q;

  // Assembly register with this cycle's expander word dropped into slot cnt.
  always_comb begin
    w_asm_new = asm_q;
    case (cnt_q)
      2'd0:    w_asm_new[127:96] = ke_round_key;
      2'd1:    w_asm_new[95:64]  = ke_round_key;
      2'd2:    w_asm_new[63:32]  = ke_round_key;
      default: w_asm_new[31:0]   = ke_round_key;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    rk_data_d  = rk_data_q;
    rk_num_d   = rk_num_q;
    rk_valid_d = rk_valid_q;
    err_d      = err_q;
    abort_d    = 1'b0;

    // Losing the key table outranks any handshake on the same edge.
    if (!ke_done && (state_q != IDLE)) begin
      state_d    = IDLE;
      rk_valid_d = 1'b0;
      cnt_d      = 2'd0;
      abort_d    = 1'b1;
    end else if (w_accept) begin
      rk_valid_d = 1'b0;
      if (req_num <= c_max_num) begin
        num_d   = req_num;
        cnt_d   = 2'd0;
        state_d = FETCH;
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        FETCH: begin
          asm_d = w_asm_new;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            rk_data_d  = w_asm_new;
            rk_num_d   = num_q;
            rk_valid_d = 1'b1;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          if (rk_ready) begin
            rk_valid_d = 1'b0;
            state_d    = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      num_q      <= 4'd0;
      cnt_q      <= 2'd0;
      asm_q      <= 128'd0;
      rk_data_q  <= 128'd0;
      rk_num_q   <= 4'd0;
      rk_valid_q <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      rk_data_q  <= rk_data_d;
      rk_num_q   <= rk_num_d;
      rk_valid_q <= rk_valid_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
    end
  end

endmodule
`default_nettype wire
